// File: rtl/buzz_round_arbiter_pkg.sv
// Shared definitions for the quiz round sequencer: round states, default sizing
// and the width helpers also used by the scoreboard and display blocks.
package buzz_round_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } round_state_e;

    localparam int DEF_N_PLAYERS  = 4;
    localparam int DEF_ARM_CYC    = 20;
    localparam int DEF_ANSWER_CYC = 10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The counter must hold the larger reload value itself.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/buzz_round_arbiter_rr_priority_pick.sv
// Combinational rotating-priority encoder: the first set request at or after
// ptr (wrapping mod N) wins.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned pos;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = ({{(32-IW){1'b0}}, ptr} + k) % N;
            if (!any && req[pos[IW-1:0]]) begin
                onehot[pos[IW-1:0]] = 1'b1;
                idx                 = pos[IW-1:0];
                any                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buzz_round_arbiter.sv
// Quiz round sequencer and first-buzz arbiter: arms a round on a start edge,
// grants the first eligible press, and turns the host judgement into score pulses.
module buzz_round_arbiter
    import buzz_round_arbiter_pkg::*;
#(
    parameter  int N_PLAYERS  = DEF_N_PLAYERS,
    parameter  int ARM_CYC    = DEF_ARM_CYC,
    parameter  int ANSWER_CYC = DEF_ANSWER_CYC,
    localparam int IDX_W      = idx_width(N_PLAYERS),
    localparam int CNT_W      = cnt_width(ARM_CYC, ANSWER_CYC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_PLAYERS-1:0] buzz,
    input  logic                 yes,
    input  logic                 no,
    output logic [N_PLAYERS-1:0] grant,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     winner_idx,
    output logic [CNT_W-1:0]     time_left,
    output logic                 score_inc,
    output logic                 score_dec,
    output logic                 timeout,
    output logic                 round_void,
    output logic [N_PLAYERS-1:0] foul,
    output logic                 busy
);

    round_state_e         state, state_d;
    logic [N_PLAYERS-1:0] buzz_q;
    logic                 start_q, yes_q, no_q;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_d;

    logic [N_PLAYERS-1:0] grant_d, foul_d;
    logic [IDX_W-1:0]     winner_idx_d;
    logic [CNT_W-1:0]     time_left_d;
    logic                 score_inc_d, score_dec_d, timeout_d, round_void_d;

    logic [N_PLAYERS-1:0] press, elig, pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any, start_edge, judge_yes, judge_no;

    assign press      = buzz & ~buzz_q;
    assign start_edge = start & ~start_q;
    // Simultaneous yes/no edges cancel and count as no judgement.
    assign judge_yes  = (yes & ~yes_q) & ~(no & ~no_q);
    assign judge_no   = (no & ~no_q) & ~(yes & ~yes_q);
    assign elig       = press & ~foul;

    assign grant_valid = (state == ST_LOCKED);
    assign busy        = (state != ST_IDLE);

    rr_priority_pick #(
        .N  (N_PLAYERS),
        .IW (IDX_W)
    ) u_pick (
        .req    (elig),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d      = state;
        grant_d      = grant;
        winner_idx_d = winner_idx;
        time_left_d  = time_left;
        rr_ptr_d     = rr_ptr;
        foul_d       = foul;
        score_inc_d  = 1'b0;
        score_dec_d  = 1'b0;
        timeout_d    = 1'b0;
        round_void_d = 1'b0;
        unique case (state)
            ST_IDLE: begin
                foul_d = foul | press;
                if (start_edge) begin
                    state_d     = ST_ARMED;
                    time_left_d = CNT_W'(ARM_CYC);
                end
            end
            ST_ARMED: begin
                if (pick_any) begin
                    state_d      = ST_LOCKED;
                    grant_d      = pick_onehot;
                    winner_idx_d = pick_idx;
                    time_left_d  = CNT_W'(ANSWER_CYC);
                    rr_ptr_d     = (pick_idx == IDX_W'(N_PLAYERS - 1)) ? '0 : pick_idx + IDX_W'(1);
                end else if (time_left == CNT_W'(1)) begin
                    state_d      = ST_IDLE;
                    time_left_d  = '0;
                    round_void_d = 1'b1;
                end else begin
                    time_left_d = time_left - CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (judge_yes || judge_no || time_left == CNT_W'(1)) begin
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    foul_d      = '0;
                    time_left_d = '0;
                    score_inc_d = judge_yes;
                    score_dec_d = ~judge_yes;
                    timeout_d   = ~judge_yes & ~judge_no;
                end else begin
                    time_left_d = time_left - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            buzz_q     <= '1;
            start_q    <= 1'b0;
            yes_q      <= 1'b0;
            no_q       <= 1'b0;
            rr_ptr     <= '0;
            grant      <= '0;
            winner_idx <= '0;
            time_left  <= '0;
            foul       <= '0;
            score_inc  <= 1'b0;
            score_dec  <= 1'b0;
            timeout    <= 1'b0;
            round_void <= 1'b0;
        end else begin
            state      <= state_d;
            buzz_q     <= buzz;
            start_q    <= start;
            yes_q      <= yes;
            no_q       <= no;
            rr_ptr     <= rr_ptr_d;
            grant      <= grant_d;
            winner_idx <= winner_idx_d;
            time_left  <= time_left_d;
            foul       <= foul_d;
            score_inc  <= score_inc_d;
            score_dec  <= score_dec_d;
            timeout    <= timeout_d;
            round_void <= round_void_d;
        end
    end

endmodule
